// File: rtl/ex_mem_wb_stage.sv
// ex_mem_wb_stage
// EX/MEM -> WB pipeline register with valid/ready flow control.
//
// A main entry (M) drives the writeback outputs. A skid entry (S) catches the
// one beat that can still arrive after out_ready drops. This keeps in_ready a
// pure register output (!S.valid). The stage also provides:
//   - synchronous flush of both entries,
//   - writeback-to-execute forwarding lookup, driven from M only,
//   - a saturating counter of back-pressured cycles.
//
// Ports
//   clk, reset                  rising-edge clock, async active-high reset
//   flush                       kills both held entries and any beat accepted
//                               in the same cycle
//   in_valid / in_ready         upstream handshake
//   in_result, in_rd, in_rs,    writeback payload from execute/memory
//   in_reg_wr, in_pc_p1,
//   in_jalr
//   out_valid / out_ready       downstream handshake
//   out_*                       payload of M; reg_wr and jalr are masked by
//                               valid so that a bubble never writes
//   fwd_src_a/b                 execute-stage source register indices
//   fwd_hit_a/b, fwd_data_a/b   forwarding match and forwarded value
//   occupancy                   number of held entries (0..2)
//   stall_cnt                   saturating count of out_valid & !out_ready
module ex_mem_wb_stage #(
    parameter int DATA_W   = 8,
    parameter int REG_W    = 3,
    parameter int PC_W     = 8,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [REG_W-1:0]  in_rs,
    input  logic              in_reg_wr,
    input  logic [PC_W-1:0]   in_pc_p1,
    input  logic              in_jalr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_rd,
    output logic [REG_W-1:0]  out_rs,
    output logic              out_reg_wr,
    output logic [PC_W-1:0]   out_pc_p1,
    output logic              out_jalr,
    input  logic [REG_W-1:0]  fwd_src_a,
    input  logic [REG_W-1:0]  fwd_src_b,
    output logic              fwd_hit_a,
    output logic              fwd_hit_b,
    output logic [DATA_W-1:0] fwd_data_a,
    output logic [DATA_W-1:0] fwd_data_b,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Packed payload layout: {result, rd, rs, reg_wr, pc_p1, jalr}
    localparam int PW = DATA_W + 2*REG_W + PC_W + 2;

    logic              m_valid_q, m_valid_d;
    logic              s_valid_q, s_valid_d;
    logic [PW-1:0]     m_data_q,  m_data_d;
    logic [PW-1:0]     s_data_q,  s_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [PW-1:0]     in_beat;
    logic              accept;
    logic              drain;

    logic [DATA_W-1:0] m_result;
    logic [REG_W-1:0]  m_rd;
    logic [REG_W-1:0]  m_rs;
    logic              m_reg_wr;
    logic [PC_W-1:0]   m_pc_p1;
    logic              m_jalr;
    logic [DATA_W-1:0] m_pc_ext;
    logic [DATA_W-1:0] m_fwd_value;

    assign in_beat = {in_result, in_rd, in_rs, in_reg_wr, in_pc_p1, in_jalr};
    assign {m_result, m_rd, m_rs, m_reg_wr, m_pc_p1, m_jalr} = m_data_q;

    assign in_ready = !s_valid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = m_valid_q & out_ready;

    always_comb begin
        m_valid_d   = m_valid_q;
        s_valid_d   = s_valid_q;
        m_data_d    = m_data_q;
        s_data_d    = s_data_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            // Payload is left stale; only the valid bits matter.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (s_valid_q && drain) begin
            // in_ready is low while S is full, so no accept can coincide.
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
        end else if (accept && (!m_valid_q || drain)) begin
            m_data_d  = in_beat;
            m_valid_d = 1'b1;
        end else if (accept) begin
            s_data_d  = in_beat;
            s_valid_d = 1'b1;
        end else if (drain) begin
            m_valid_d = 1'b0;
        end

        if (m_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_q   <= 1'b0;
            s_valid_q   <= 1'b0;
            m_data_q    <= '0;
            s_data_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            m_valid_q   <= m_valid_d;
            s_valid_q   <= s_valid_d;
            m_data_q    <= m_data_d;
            s_data_q    <= s_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid  = m_valid_q;
    assign out_result = m_result;
    assign out_rd     = m_rd;
    assign out_rs     = m_rs;
    assign out_reg_wr = m_reg_wr & m_valid_q;
    assign out_pc_p1  = m_pc_p1;
    assign out_jalr   = m_jalr & m_valid_q;
    assign occupancy  = {1'b0, m_valid_q} + {1'b0, s_valid_q};
    assign stall_cnt  = stall_cnt_q;

    // The link value is PC+1, zero-extended or truncated to the data width.
    generate
        if (PC_W >= DATA_W) begin : g_pc_trunc
            assign m_pc_ext = m_pc_p1[DATA_W-1:0];
        end else begin : g_pc_zext
            assign m_pc_ext = {{(DATA_W-PC_W){1'b0}}, m_pc_p1};
        end
    endgenerate

    assign m_fwd_value = m_jalr ? m_pc_ext : m_result;

    // Two identical lookup ports, indexed 0 = a, 1 = b.
    logic [REG_W-1:0]  fwd_src  [2];
    logic              fwd_hit  [2];
    logic [DATA_W-1:0] fwd_data [2];

    assign fwd_src[0] = fwd_src_a;
    assign fwd_src[1] = fwd_src_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic src_is_zero_reg;
            assign src_is_zero_reg = (ZERO_REG != 0) && (fwd_src[gi] == '0);
            assign fwd_hit[gi]  = m_valid_q & m_reg_wr & (m_rd == fwd_src[gi])
                                  & !src_is_zero_reg;
            assign fwd_data[gi] = fwd_hit[gi] ? m_fwd_value : '0;
        end
    endgenerate

    assign fwd_hit_a  = fwd_hit[0];
    assign fwd_hit_b  = fwd_hit[1];
    assign fwd_data_a = fwd_data[0];
    assign fwd_data_b = fwd_data[1];

endmodule

// File: doc/ex_mem_wb_stage.md
# ex_mem_wb_stage

Parametrised successor to the fixed EX/MEM→WB pipeline register, sitting between the execute/memory and writeback stages of the pipelined core. It carries the same writeback payload (result, destination register, RS field, register-write enable, PC+1, JALR flag) with configurable widths. It adds valid/ready flow control with a two-entry skid buffer, synchronous flush, and writeback-to-execute forwarding lookup. A saturating stall counter is included for performance debug.

## Interface

Parameters:
- DATA_W, 8, width of result and PC+1 payloads
- REG_W, 3, register-index width
- PC_W, 8, PC+1 width
- ZERO_REG, 1, when 1 register index 0 never produces a forwarding hit
- CNT_W, 16, stall counter width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat
- in_result  in  DATA_W  ALU/memory result
- in_rd  in  REG_W  destination register (rt or rd)
- in_rs  in  REG_W  RS field
- in_reg_wr  in  1  register-write enable
- in_pc_p1  in  PC_W  PC+1 for JAL/JALR link
- in_jalr  in  1  JALR writeback select
- out_valid  out  1  beat presented to writeback
- out_ready  in  1  writeback consumes beat
- out_result, out_rd, out_rs, out_reg_wr, out_pc_p1, out_jalr  out  as inputs  registered payload
- fwd_src_a, fwd_src_b  in  REG_W  execute-stage source indices
- fwd_hit_a, fwd_hit_b  out  1  forwarding match
- fwd_data_a, fwd_data_b  out  DATA_W  forwarded value
- occupancy  out  2  entries held (0..2)
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles

## Operation

- Storage: main entry M (drives out_*) and skid entry S, each with a valid bit.
- in_ready = !S.valid (purely registered, no combinational path from out_ready).
- Accept = in_valid & in_ready. Drain = M.valid & out_ready.
- Update priority, highest first:
  - Flush: M.valid and S.valid are cleared, and any beat accepted this cycle is discarded. Payload registers may keep stale data.
  - S valid and drain: M←S, S cleared. No accept is possible in this case.
  - M empty or draining, and accept: M←input.
  - M valid, not draining, and accept: S←input; in_ready drops next cycle.
  - Otherwise hold.
- out_valid = M.valid. out_reg_wr = M.reg_wr & M.valid. out_jalr = M.jalr & M.valid. A bubble therefore never writes the register file.
- Forwarding (combinational from M only):
  - fwd_hit_x = M.valid & M.reg_wr & (M.rd == fwd_src_x) & !(ZERO_REG & fwd_src_x==0).
  - fwd_data_x = M.jalr ? zero-extended/truncated M.pc_p1 to DATA_W : M.result.
  - fwd_data_x is 0 when fwd_hit_x is 0.
- occupancy = M.valid + S.valid.
- stall_cnt increments on every cycle with out_valid & !out_ready and saturates at all-ones. It is cleared only by reset; flush does not clear it.

## Timing

- Reset (asynchronous assert, synchronous release by clock): M.valid=S.valid=0, all payload=0, stall_cnt=0. Consequently out_valid=0, in_ready=1, occupancy=0, fwd_hit=0, and all out_* equal 0.
- Latency: a beat accepted at edge N appears on out_* after edge N (visible during cycle N+1). This matches the single-cycle latency of the fixed register.
- Throughput: one beat per cycle while out_ready=1.
- Back-pressure: after out_ready falls, at most one further beat is accepted, into S. in_ready is low from the following cycle.
- Ordering: strict FIFO order. A beat in S is always presented after M.
- Full (occupancy=2) with out_ready=1: M←S and in_ready rises the next cycle. A simultaneous accept cannot occur.
- Flush together with in_valid/out_ready: flush wins, occupancy=0 next cycle, and no beat is transferred. The handshake on out_* in the flush cycle still counts as consumed by downstream.
- Reset mid-stream: held beats are lost, and outputs go to their reset values immediately (asynchronously).

## Test plan

- Reset then stream: 4 beats with result 0x11..0x44, rd=1..4, out_ready=1 → each appears one cycle after acceptance, in order, occupancy ≤1, stall_cnt=0.
- Back-pressure: out_ready=0 while sending beats A=0x5A and B=0xA5 → occupancy=2, in_ready=0, stall_cnt counts up. Then out_ready=1 → A, then B, on consecutive cycles; in_ready returns high.
- Flush at full: occupancy=2, assert flush with in_valid=1 → next cycle out_valid=0, occupancy=0, out_reg_wr=0, and the flushed input beat never appears.
- Forwarding: M holds rd=3, reg_wr=1, result=0x7E, with fwd_src_a=3 and fwd_src_b=2 → hit_a=1, data_a=0x7E, hit_b=0. With jalr=1 and pc_p1=0x21 → data_a=0x21. With rd=0 and ZERO_REG=1, fwd_src=0 → no hit.
- Stall counter saturation: CNT_W=4 with out_valid held and out_ready=0 for 20 cycles → stall_cnt stops at 15.
- Asynchronous reset mid-operation: assert reset between clock edges with occupancy=2 → out_valid=0, in_ready=1, stall_cnt=0 immediately, without waiting for a clock edge.
